i2s_tx_ser: RTL

I2S_TX_SER -- requirements
Module: i2s_tx_ser

---
 rtl/i2s_tx_ser.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/i2s_tx_ser.sv
// i2s_tx_ser: Philips I2S transmit serializer with a one-word prefetch buffer.
// sck_i/ws_i come from an external bit-clock domain and are oversampled by clk_i.
module i2s_tx_ser #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic        lsb_i,
  input  logic        mono_i,
  input  logic [1:0]  dal_i,
  input  logic        sck_i,
  input  logic        ws_i,
  input  logic        tx_valid_i,
  output logic        tx_ready_o,
  input  logic [31:0] tx_data_i,
  output logic        sd_o,
  output logic        busy_o,
  output logic        underrun_o
);

  // state | meaning
  // IDLE  | disabled; datapath held clear
  // SYNC  | enabled, waiting for the first left-channel word start
  // RUN   | serializing one word per ws slot

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] ws_sync;
  logic        sck_d;
  logic        sck_s, ws_s;
  logic        sck_rise, sck_fall;
  logic        ws_smp, ws_prv;
  logic        word_start;

  logic [31:0] shift_q;
  logic [31:0] hold_data;
  logic [31:0] last_left;
  logic        hold_vld;
  logic        lsb_q;
  logic        sd_q;
  logic        underrun_q;
  logic [4:0]  bits_left;

  logic        clr, accept, load, need_hold, consume;
  logic [31:0] src_word, aligned, masked, load_word, load_shifted;
  logic [4:0]  load_cnt;
  logic        load_bit;

  assign sck_s      = sck_sync[SYNC_STAGES-1];
  assign ws_s       = ws_sync[SYNC_STAGES-1];
  assign sck_rise   = sck_s & ~sck_d;
  assign sck_fall   = ~sck_s & sck_d;
  assign word_start = sck_fall & (ws_smp != ws_prv);

  // A disabled block clears the datapath one edge after en_i drops.
  assign clr        = ~en_i | (state_q == IDLE);
  assign tx_ready_o = en_i & ~hold_vld & ~rst_i;
  assign accept     = tx_valid_i & tx_ready_o;
  // SYNC only leaves on a left word start, so loads there are always left words.
  assign load       = word_start & ((state_q == RUN) | ((state_q == SYNC) & ~ws_smp));
  // Mono right channel repeats the last left word and leaves the prefetch alone.
  assign need_hold  = ~(mono_i & ws_smp);
  assign consume    = load & need_hold;

  assign sd_o       = sd_q;
  assign underrun_o = underrun_q;
  assign busy_o     = (state_q == RUN) & ((bits_left != 5'd0) | hold_vld);

  // Bring the bit clock and word select into clk_i and keep the previous sck level.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sck_sync <= '0;
      ws_sync  <= '0;
      sck_d    <= 1'b0;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck_i};
      ws_sync  <= {ws_sync[SYNC_STAGES-2:0], ws_i};
      sck_d    <= sck_s;
    end
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state: wait for a left word start before emitting anything.
  always_comb begin
    state_d = state_q;
    if (!en_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = SYNC;
        SYNC:    if (word_start && !ws_smp) state_d = RUN;
        RUN:     state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // Shape the outgoing word for the configuration seen at this word start.
  always_comb begin
    src_word = 32'h0;
    if (mono_i && ws_smp) src_word = last_left;
    else if (hold_vld)    src_word = hold_data;
    aligned  = src_word;
    masked   = src_word;
    load_cnt = 5'd31;
    case (dal_i)
      2'd0: begin
        aligned  = {src_word[7:0], 24'h0};
        masked   = {24'h0, src_word[7:0]};
        load_cnt = 5'd7;
      end
      2'd1: begin
        aligned  = {src_word[15:0], 16'h0};
        masked   = {16'h0, src_word[15:0]};
        load_cnt = 5'd15;
      end
      2'd2: begin
        aligned  = {src_word[23:0], 8'h0};
        masked   = {8'h0, src_word[23:0]};
        load_cnt = 5'd23;
      end
      default: begin
        aligned  = src_word;
        masked   = src_word;
        load_cnt = 5'd31;
      end
    endcase
    load_word    = lsb_i ? masked : aligned;
    load_bit     = lsb_i ? load_word[0] : load_word[31];
    load_shifted = lsb_i ? {1'b0, load_word[31:1]} : {load_word[30:0], 1'b0};
  end

  // Serializer datapath: ws sampling, prefetch buffer, shifter and bit timer.
  // The bit on sd_o has already left shift_q; bits_left counts the rest down.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ws_smp     <= 1'b0;
      ws_prv     <= 1'b0;
      shift_q    <= 32'h0;
      hold_data  <= 32'h0;
      last_left  <= 32'h0;
      hold_vld   <= 1'b0;
      lsb_q      <= 1'b0;
      sd_q       <= 1'b0;
      underrun_q <= 1'b0;
      bits_left  <= 5'd0;
    end else if (clr) begin
      ws_smp     <= 1'b0;
      ws_prv     <= 1'b0;
      shift_q    <= 32'h0;
      last_left  <= 32'h0;
      lsb_q      <= 1'b0;
      sd_q       <= 1'b0;
      underrun_q <= 1'b0;
      bits_left  <= 5'd0;
      // A handshake taken while leaving IDLE must not be dropped.
      hold_vld   <= accept;
      if (accept) hold_data <= tx_data_i;
    end else begin
      underrun_q <= consume & ~hold_vld;
      if (sck_rise) begin
        ws_smp <= ws_s;
        ws_prv <= ws_smp;
      end
      if (load) begin
        shift_q   <= load_shifted;
        sd_q      <= load_bit;
        bits_left <= load_cnt;
        lsb_q     <= lsb_i;
        if (!ws_smp) last_left <= src_word;
      end else if (sck_fall && state_q == RUN) begin
        if (bits_left != 5'd0) begin
          sd_q      <= lsb_q ? shift_q[0] : shift_q[31];
          shift_q   <= lsb_q ? {1'b0, shift_q[31:1]} : {shift_q[30:0], 1'b0};
          bits_left <= bits_left - 5'd1;
        end else begin
          sd_q <= 1'b0;
        end
      end
      hold_vld <= (hold_vld & ~consume) | accept;
      if (accept) hold_data <= tx_data_i;
    end
  end

endmodule
